mem_lsu: RTL and testbench

//  MEM pipeline stage, downstream of ex. Registers EX results, performs load/store

---
 rtl/mem_lsu.sv | 204 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM pipeline stage: registers EX results, runs load/store accesses over a
// req/gnt/rvalid data bus, and stalls IF..EX while an access is in flight.
module mem_lsu #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [XLEN-1:0]   ex_wdata_i,
  input  logic [3:0]        ex_memop_i,
  input  logic [XLEN-1:0]   ex_sdata_i,
  input  logic [31:0]       ex_hi_i,
  input  logic [31:0]       ex_lo_i,
  input  logic              ex_whilo_i,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [XLEN-1:0]   dm_addr_o,
  output logic [7:0]        dm_be_o,
  output logic [XLEN-1:0]   dm_wdata_o,
  input  logic              dm_gnt_i,
  input  logic              dm_rvalid_i,
  input  logic [XLEN-1:0]   dm_rdata_i,
  output logic [REG_AW-1:0] mem_wd_o,
  output logic              mem_wreg_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [31:0]       mem_hi_o,
  output logic [31:0]       mem_lo_o,
  output logic              mem_whilo_o,
  output logic              misalign_o,
  output logic              stallreq_from_mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;
  state_e state_q, state_d;

  // access latches, stable on the bus for the whole REQ phase
  logic              st_q, sgn_q;
  logic [1:0]        size_q;
  logic [2:0]        off_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic [7:0]        be_q;
  logic [REG_AW-1:0] wd_q;
  logic              wreg_q;

  // stage output registers
  logic [REG_AW-1:0] mem_wd_q;
  logic              mem_wreg_q, whilo_q, misalign_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [31:0]       hi_q, lo_q;

  // EX op decode: size 0 B, 1 H, 2 W, 3 D
  logic       is_ld, is_st, is_mem, ld_sgn, aligned, start, mis;
  logic [1:0] size;
  logic [7:0] be_d;
  logic [XLEN-1:0] ld_sh, ld_res;

  // decode memop, alignment check and byte-lane enables for the EX op
  always_comb begin
    is_ld = 1'b0; is_st = 1'b0; ld_sgn = 1'b0; size = 2'd0; aligned = 1'b1;
    case (ex_memop_i)
      4'd1:  begin is_ld = 1'b1; ld_sgn = 1'b1; size = 2'd0; end
      4'd2:  begin is_ld = 1'b1; ld_sgn = 1'b1; size = 2'd1; end
      4'd3:  begin is_ld = 1'b1; ld_sgn = 1'b1; size = 2'd2; end
      4'd4:  begin is_ld = 1'b1; size = 2'd3; end
      4'd5:  begin is_ld = 1'b1; size = 2'd0; end
      4'd6:  begin is_ld = 1'b1; size = 2'd1; end
      4'd7:  begin is_ld = 1'b1; size = 2'd2; end
      4'd8:  begin is_st = 1'b1; size = 2'd0; end
      4'd9:  begin is_st = 1'b1; size = 2'd1; end
      4'd10: begin is_st = 1'b1; size = 2'd2; end
      4'd11: begin is_st = 1'b1; size = 2'd3; end
      default: ;
    endcase
    is_mem = is_ld | is_st;
    case (size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~ex_wdata_i[0];
      2'd2:    aligned = (ex_wdata_i[1:0] == 2'b00);
      default: aligned = (ex_wdata_i[2:0] == 3'b000);
    endcase
    case (size)
      2'd0:    be_d = 8'h01 << ex_wdata_i[2:0];
      2'd1:    be_d = 8'h03 << ex_wdata_i[2:0];
      2'd2:    be_d = 8'h0F << ex_wdata_i[2:0];
      default: be_d = 8'hFF;
    endcase
  end

  assign start = (state_q == IDLE) & ex_valid_i & is_mem & aligned;
  assign mis   = (state_q == IDLE) & ex_valid_i & is_mem & ~aligned;

  // pick the addressed lane out of the returned doubleword and extend it
  always_comb begin
    ld_sh  = dm_rdata_i >> {off_q, 3'b000};
    ld_res = ld_sh;
    case (size_q)
      2'd0:    ld_res = {{(XLEN-8){sgn_q & ld_sh[7]}}, ld_sh[7:0]};
      2'd1:    ld_res = {{(XLEN-16){sgn_q & ld_sh[15]}}, ld_sh[15:0]};
      2'd2:    ld_res = {{(XLEN-32){sgn_q & ld_sh[31]}}, ld_sh[31:0]};
      default: ld_res = ld_sh;
    endcase
  end

  // FSM next state and stall; stall is low in DONE so EX can move on
  always_comb begin
    state_d = state_q;
    stallreq_from_mem = 1'b0;
    case (state_q)
      IDLE: begin
        stallreq_from_mem = start;
        if (start) state_d = REQ;
      end
      REQ: begin
        stallreq_from_mem = 1'b1;
        if (dm_gnt_i) state_d = st_q ? DONE : WAIT_R;
      end
      WAIT_R: begin
        stallreq_from_mem = 1'b1;
        if (dm_rvalid_i) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // datapath: pass-through in IDLE, access latching, writeback on completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= 1'b0; sgn_q <= 1'b0; size_q <= 2'd0; off_q <= 3'd0;
      addr_q <= '0; wdata_q <= '0; be_q <= 8'h00; wd_q <= '0; wreg_q <= 1'b0;
      mem_wd_q <= '0; mem_wreg_q <= 1'b0; mem_wdata_q <= '0;
      hi_q <= 32'd0; lo_q <= 32'd0; whilo_q <= 1'b0; misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          hi_q    <= ex_hi_i;
          lo_q    <= ex_lo_i;
          whilo_q <= ex_valid_i & ex_whilo_i & ~is_mem;
          if (start) begin
            st_q    <= is_st;
            sgn_q   <= ld_sgn;
            size_q  <= size;
            off_q   <= ex_wdata_i[2:0];
            addr_q  <= {ex_wdata_i[XLEN-1:3], 3'b000};
            be_q    <= be_d;
            wdata_q <= ex_sdata_i << {ex_wdata_i[2:0], 3'b000};
            wd_q    <= ex_wd_i;
            wreg_q  <= ex_wreg_i & is_ld;
            mem_wreg_q <= 1'b0;
          end else if (mis) begin
            misalign_q <= 1'b1;
            mem_wreg_q <= 1'b0;
          end else begin
            mem_wd_q    <= ex_wd_i;
            mem_wreg_q  <= ex_valid_i & ex_wreg_i;
            mem_wdata_q <= ex_wdata_i;
          end
        end
        REQ: begin
          whilo_q <= 1'b0;
          if (dm_gnt_i && st_q) begin
            mem_wd_q   <= wd_q;
            mem_wreg_q <= 1'b0;
          end
        end
        WAIT_R: begin
          whilo_q <= 1'b0;
          if (dm_rvalid_i) begin
            mem_wd_q    <= wd_q;
            mem_wreg_q  <= wreg_q;
            mem_wdata_q <= ld_res;
          end
        end
        default: begin
          mem_wreg_q <= 1'b0;
          whilo_q    <= 1'b0;
        end
      endcase
    end
  end

  assign dm_req_o    = (state_q == REQ);
  assign dm_we_o     = st_q;
  assign dm_addr_o   = addr_q;
  assign dm_be_o     = be_q;
  assign dm_wdata_o  = wdata_q;
  assign mem_wd_o    = mem_wd_q;
  assign mem_wreg_o  = mem_wreg_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_hi_o    = hi_q;
  assign mem_lo_o    = lo_q;
  assign mem_whilo_o = whilo_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: stimulus pushes expectations, a negedge
// monitor pops and compares whenever the DUT presents bus/writeback/HI-LO.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid_i = 0, ex_wreg_i = 0, ex_whilo_i = 0;
  logic [4:0]  ex_wd_i = 0;
  logic [63:0] ex_wdata_i = 0, ex_sdata_i = 0;
  logic [3:0]  ex_memop_i = 0;
  logic [31:0] ex_hi_i = 0, ex_lo_i = 0;
  logic        dm_req_o, dm_we_o, dm_gnt_i = 0, dm_rvalid_i = 0;
  logic [63:0] dm_addr_o, dm_wdata_o, dm_rdata_i = 0;
  logic [7:0]  dm_be_o;
  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o, mem_whilo_o, misalign_o, stallreq_from_mem;
  logic [63:0] mem_wdata_o;
  logic [31:0] mem_hi_o, mem_lo_o;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i),
    .ex_wdata_i(ex_wdata_i), .ex_memop_i(ex_memop_i), .ex_sdata_i(ex_sdata_i),
    .ex_hi_i(ex_hi_i), .ex_lo_i(ex_lo_i), .ex_whilo_i(ex_whilo_i),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_be_o(dm_be_o),
    .dm_wdata_o(dm_wdata_o), .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i),
    .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
    .mem_hi_o(mem_hi_o), .mem_lo_o(mem_lo_o), .mem_whilo_o(mem_whilo_o),
    .misalign_o(misalign_o), .stallreq_from_mem(stallreq_from_mem)
  );

  typedef struct {logic [63:0] addr; logic [7:0] be; logic we; logic [63:0] wdata;} bus_t;
  typedef struct {logic [4:0] wd; logic [63:0] data;} wb_t;
  bus_t        bus_q[$];
  wb_t         wb_q[$];
  logic [63:0] hl_q[$];
  bus_t        mb;
  wb_t         mw;
  logic [63:0] mh;
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [63:0] act);
    total++; bad++;
    $display("FAIL %s: got %h want nothing", nm, act);
  endtask

  // monitor: compare every DUT presentation against the scoreboard
  always @(negedge clk) if (rst) begin
    if (mem_wreg_o) begin
      if (wb_q.size() == 0) flag("wb_unexpected", mem_wdata_o);
      else begin
        mw = wb_q.pop_front();
        chk("wb_wd", {59'd0, mem_wd_o}, {59'd0, mw.wd});
        chk("wb_data", mem_wdata_o, mw.data);
      end
    end
    if (mem_whilo_o) begin
      if (hl_q.size() == 0) flag("hilo_unexpected", {mem_hi_o, mem_lo_o});
      else begin
        mh = hl_q.pop_front();
        chk("hilo", {mem_hi_o, mem_lo_o}, mh);
      end
    end
    if (dm_req_o && dm_gnt_i) begin
      if (bus_q.size() == 0) flag("bus_unexpected", dm_addr_o);
      else begin
        mb = bus_q.pop_front();
        chk("bus_addr", dm_addr_o, mb.addr);
        chk("bus_be", {56'd0, dm_be_o}, {56'd0, mb.be});
        chk("bus_we", {63'd0, dm_we_o}, {63'd0, mb.we});
        if (mb.we) chk("bus_wdata", dm_wdata_o, mb.wdata);
      end
    end
  end

  task automatic alu(input logic [4:0] wd, input logic [63:0] d, input logic wreg, input logic whilo,
                     input logic [31:0] hi, input logic [31:0] lo);
    @(posedge clk); #1;
    ex_valid_i = 1; ex_memop_i = 0; ex_wd_i = wd; ex_wdata_i = d; ex_wreg_i = wreg;
    ex_whilo_i = whilo; ex_hi_i = hi; ex_lo_i = lo;
    if (wreg) wb_q.push_back('{wd, d});
    if (whilo) hl_q.push_back({hi, lo});
    @(negedge clk); chk("alu_stall", {63'd0, stallreq_from_mem}, 64'd0);
    @(posedge clk); #1;
    ex_valid_i = 0; ex_wreg_i = 0; ex_whilo_i = 0;
    @(negedge clk); chk("alu_latency", {63'd0, mem_wreg_o}, {63'd0, wreg});
  endtask

  // memory op with bus responder: gnt in cycle gd, rvalid in cycle rd (cycle 0 = EX presents op)
  task automatic mop(input string nm, input logic [3:0] op, input logic [63:0] addr, input logic [63:0] sd,
                     input logic [4:0] wd, input int gd, input int rd, input logic [63:0] rdata,
                     input logic [7:0] be_e, input logic [63:0] bw_e, input logic [63:0] wb_e, input int stall_e);
    int c, stalls;
    bit ld;
    ld = (op < 4'd8);
    @(posedge clk); #1;
    ex_valid_i = 1; ex_memop_i = op; ex_wdata_i = addr; ex_sdata_i = sd; ex_wd_i = wd;
    ex_wreg_i = 1; ex_whilo_i = 1; ex_hi_i = 32'h5A5A5A5A; ex_lo_i = 32'hA5A5A5A5;
    bus_q.push_back('{{addr[63:3], 3'b000}, be_e, !ld, bw_e});
    if (ld) wb_q.push_back('{wd, wb_e});
    c = 0; stalls = 0;
    forever begin
      @(negedge clk);
      if (stallreq_from_mem) stalls++;
      else break;
      if (c >= 60) begin flag({nm, "_timeout"}, c); break; end
      @(posedge clk); #1;
      c++;
      dm_gnt_i    = (c == gd);
      dm_rvalid_i = (c == rd) || (ld && c >= 1 && c < gd);
      dm_rdata_i  = (c == rd) ? rdata : 64'hDEAD_DEAD_DEAD_DEAD;
    end
    chk({nm, "_stalls"}, stalls, stall_e);
    @(posedge clk); #1;
    ex_valid_i = 0; ex_wreg_i = 0; ex_whilo_i = 0; ex_memop_i = 0;
    dm_gnt_i = 0; dm_rvalid_i = 0;
  endtask

  task automatic misal(input string nm, input logic [3:0] op, input logic [63:0] addr);
    @(posedge clk); #1;
    ex_valid_i = 1; ex_memop_i = op; ex_wdata_i = addr; ex_wreg_i = 1; ex_wd_i = 5'd9;
    @(negedge clk);
    chk({nm, "_stall"}, {63'd0, stallreq_from_mem}, 64'd0);
    @(posedge clk); #1;
    ex_valid_i = 0; ex_wreg_i = 0; ex_memop_i = 0;
    @(negedge clk);
    chk({nm, "_pulse"}, {63'd0, misalign_o}, 64'd1);
    chk({nm, "_noreq"}, {63'd0, dm_req_o}, 64'd0);
    @(negedge clk);
    chk({nm, "_pulse_end"}, {63'd0, misalign_o}, 64'd0);
    chk({nm, "_noreq2"}, {63'd0, dm_req_o}, 64'd0);
  endtask

  initial begin
    #3;
    chk("reset_ctl", {45'd0, dm_req_o, dm_we_o, dm_be_o, mem_wreg_o, mem_whilo_o, misalign_o,
                      stallreq_from_mem, mem_wd_o}, 64'd0);
    chk("reset_data", dm_addr_o | dm_wdata_o | mem_wdata_o | {mem_hi_o, mem_lo_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1;

    // pass-through and HI/LO forward
    alu(5'd5, 64'h1234, 1'b1, 1'b0, 32'd0, 32'd0);
    alu(5'd6, 64'hFEDC, 1'b1, 1'b1, 32'h1111_2222, 32'h3333_4444);

    // loads
    mop("lb",  4'd1, 64'h1003, 0, 5'd10, 1, 2, 64'h0000_0000_8000_0000, 8'h08, 0, 64'hFFFF_FFFF_FFFF_FF80, 3);
    mop("lhu", 4'd6, 64'h2006, 0, 5'd11, 2, 4, 64'hBEEF_0000_0000_0000, 8'hC0, 0, 64'h0000_0000_0000_BEEF, 5);
    mop("lh",  4'd2, 64'h2006, 0, 5'd12, 1, 2, 64'hBEEF_0000_0000_0000, 8'hC0, 0, 64'hFFFF_FFFF_FFFF_BEEF, 3);
    mop("lw",  4'd3, 64'h54,   0, 5'd13, 1, 2, 64'h8765_4321_0000_0000, 8'hF0, 0, 64'hFFFF_FFFF_8765_4321, 3);
    mop("lwu", 4'd7, 64'h54,   0, 5'd14, 1, 2, 64'h8765_4321_0000_0000, 8'hF0, 0, 64'h0000_0000_8765_4321, 3);
    mop("ld",  4'd4, 64'h58,   0, 5'd15, 1, 3, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 64'h0123_4567_89AB_CDEF, 4);
    mop("lbu", 4'd5, 64'h1007, 0, 5'd16, 1, 2, 64'h9A00_0000_0000_0000, 8'h80, 0, 64'h0000_0000_0000_009A, 3);

    // stores
    mop("sw", 4'd10, 64'h30, 64'hDEADBEEF, 5'd1, 3, -1, 0, 8'h0F, 64'h0000_0000_DEAD_BEEF, 0, 4);
    mop("sb", 4'd8,  64'h35, 64'hAB,       5'd2, 1, -1, 0, 8'h20, 64'h0000_AB00_0000_0000, 0, 2);
    mop("sh", 4'd9,  64'h3A, 64'h5566,     5'd3, 1, -1, 0, 8'h0C, 64'h0000_0000_5566_0000, 0, 2);
    mop("sd", 4'd11, 64'h48, 64'h1122_3344_5566_7788, 5'd4, 2, -1, 0, 8'hFF, 64'h1122_3344_5566_7788, 0, 3);

    // misaligned accesses
    misal("mis_lw", 4'd3, 64'h4002);
    misal("mis_ld", 4'd4, 64'h4004);
    misal("mis_sh", 4'd9, 64'h4001);

    // back-to-back pass-through after accesses
    alu(5'd7, 64'hAAAA_5555_0000_FFFF, 1'b1, 1'b0, 32'd0, 32'd0);

    // async reset during WAIT_R, then a late rvalid
    @(posedge clk); #1;
    ex_valid_i = 1; ex_memop_i = 4'd4; ex_wdata_i = 64'h50; ex_wd_i = 5'd7; ex_wreg_i = 1;
    bus_q.push_back('{64'h50, 8'hFF, 1'b0, 64'd0});
    @(posedge clk); #1; dm_gnt_i = 1;
    @(posedge clk); #1; dm_gnt_i = 0;
    @(negedge clk); chk("wait_stall", {63'd0, stallreq_from_mem}, 64'd1);
    #1 rst = 0; ex_valid_i = 0; ex_memop_i = 0; ex_wreg_i = 0;
    #1;
    chk("rst_req", {63'd0, dm_req_o}, 64'd0);
    chk("rst_stall", {63'd0, stallreq_from_mem}, 64'd0);
    chk("rst_outs", dm_addr_o | mem_wdata_o | {59'd0, mem_wd_o}, 64'd0);
    @(posedge clk); #1; dm_rvalid_i = 1; dm_rdata_i = 64'h7777_7777_7777_7777;
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; dm_rvalid_i = 0;
    @(negedge clk);
    chk("post_rst_wreg", {63'd0, mem_wreg_o}, 64'd0);
    chk("post_rst_req", {63'd0, dm_req_o}, 64'd0);
    alu(5'd3, 64'h77, 1'b1, 1'b1, 32'hCAFE_0001, 32'hCAFE_0002);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wb_q_empty", wb_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    chk("hl_q_empty", hl_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
